// File: rtl/fetch_queue.sv
// Fetch stage: PC register with sequential increment and branch redirect, feeding a
// DEPTH-entry {PC, instruction} FIFO toward decode. Optional macro FETCH_PERF_EN adds perf counters.
module fetch_queue #(
    parameter int           N        = 64,
    parameter int           I_W      = 32,
    parameter int           DEPTH    = 4,
    parameter int           STEP     = 4,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       PCSrc_F,
    input  logic [N-1:0]               PCBranch_F,
    output logic [N-1:0]               imem_addr_F,
    output logic                       imem_req_F,
    input  logic [I_W-1:0]             imem_data_F,
    output logic                       instr_valid_D,
    input  logic                       instr_ready_D,
    output logic [I_W-1:0]             instr_D,
    output logic [N-1:0]               pc_D,
`ifdef FETCH_PERF_EN
    output logic [31:0]                perf_fetch_F,
    output logic [31:0]                perf_flush_F,
`endif
    output logic [$clog2(DEPTH):0]     count_F
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]   pc_r;
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic [N-1:0]   mem_pc_r    [DEPTH];
    logic [I_W-1:0] mem_instr_r [DEPTH];
    logic           valid_s;
    logic           pop_s;
    logic           push_s;

    // Handshake decode; a redirect cycle suppresses both pop and push.
    always_comb begin
        valid_s = (count_r != {CW{1'b0}}) && !PCSrc_F;
        pop_s   = valid_s && instr_ready_D;
        push_s  = reset && !PCSrc_F && ((count_r < CW'(DEPTH)) || pop_s);
    end

    assign imem_addr_F   = pc_r;
    assign imem_req_F    = push_s;
    assign instr_valid_D = valid_s;
    assign instr_D       = mem_instr_r[rd_ptr_r];
    assign pc_D          = mem_pc_r[rd_ptr_r];
    assign count_F       = count_r;

    // PC, pointers and occupancy; redirect flushes by snapping rd_ptr onto wr_ptr.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_r     <= RESET_PC;
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (PCSrc_F) begin
            pc_r     <= PCBranch_F;
            rd_ptr_r <= wr_ptr_r;
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                pc_r     <= pc_r + N'(STEP);
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                pc_r     <= pc_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_pc_r[wr_ptr_r]    <= pc_r;
            mem_instr_r[wr_ptr_r] <= imem_data_F;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_r;
    logic [31:0] perf_flush_r;

    // Saturating push and redirect counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetch_r <= 32'd0;
            perf_flush_r <= 32'd0;
        end else begin
            if (push_s && (perf_fetch_r != 32'hFFFF_FFFF)) begin
                perf_fetch_r <= perf_fetch_r + 32'd1;
            end else begin
                perf_fetch_r <= perf_fetch_r;
            end
            if (PCSrc_F && (perf_flush_r != 32'hFFFF_FFFF)) begin
                perf_flush_r <= perf_flush_r + 32'd1;
            end else begin
                perf_flush_r <= perf_flush_r;
            end
        end
    end

    assign perf_fetch_F = perf_fetch_r;
    assign perf_flush_F = perf_flush_r;
`endif

endmodule
